// File: rtl/tff_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module      : tff_ctrl_pkg
// Description : Shared state encoding and direction constants for the
//               T-flip-flop counter controller.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package tff_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic c_DIR_UP   = 1'b0;
    localparam logic c_DIR_DOWN = 1'b1;

endpackage

`default_nettype wire

// File: rtl/tff_bank.sv
//------------------------------------------------------------------------------
// Module      : tff_bank
// Description : Bank of WIDTH T flip-flops; each bit flips when its tog bit is
//               set. Holds no counting policy of its own.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tff_bank #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] tog,
    output logic [WIDTH-1:0] q
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic r_bit_q;
        logic w_bit_d;

        always_comb begin
            w_bit_d = r_bit_q ^ tog[i];
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_bit_q <= 1'b0;
            end else begin
                r_bit_q <= w_bit_d;
            end
        end

        assign q[i] = r_bit_q;
    end

endmodule

`default_nettype wire

// File: rtl/tff_count_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tff_count_ctrl
// Description : Programmable modulo counter controller driving a T-FF bank
//               through a per-bit toggle vector (step / load / hold).
//               Optional macro TFF_CTRL_PAUSE_EN adds a `pause` input.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tff_count_ctrl
    import tff_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
`ifdef TFF_CTRL_PAUSE_EN
    input  logic             pause,
`endif
    input  logic             dir,
    input  logic             reload,
    input  logic             cfg_we,
    input  logic [WIDTH-1:0] cfg_limit,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             tc
);

    state_e           r_state_q,  w_state_d;
    logic             r_dir_q,    w_dir_d;
    logic             r_reload_q, w_reload_d;
    logic [WIDTH-1:0] r_limit_q,  w_limit_d;

    logic [WIDTH-1:0] w_count;
    logic [WIDTH-1:0] w_tog;
    logic [WIDTH-1:0] w_step;
    logic [WIDTH-1:0] w_init;
    logic [WIDTH-1:0] w_term;
    logic             w_pause;
    logic             w_tc;

`ifdef TFF_CTRL_PAUSE_EN
    assign w_pause = pause;
`else
    assign w_pause = 1'b0;
`endif

    assign w_init = (r_dir_q == c_DIR_DOWN) ? r_limit_q : '0;
    assign w_term = (r_dir_q == c_DIR_DOWN) ? '0 : r_limit_q;
    assign w_tc   = (r_state_q == ST_RUN) && (w_count == w_term) && !w_pause;

    // Ripple carry/borrow: a bit toggles when all lower bits are 1 (up) or 0 (down).
    always_comb begin
        logic w_carry;
        w_step  = '0;
        w_carry = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            w_step[i] = w_carry;
            w_carry   = w_carry & ((r_dir_q == c_DIR_UP) ? w_count[i] : ~w_count[i]);
        end
    end

    always_comb begin
        w_state_d  = r_state_q;
        w_dir_d    = r_dir_q;
        w_reload_d = r_reload_q;
        w_limit_d  = r_limit_q;
        w_tog      = '0;

        if (cfg_we && (r_state_q == ST_IDLE || r_state_q == ST_DONE)) begin
            w_limit_d = cfg_limit;
        end

        case (r_state_q)
            ST_IDLE, ST_DONE: begin
                if (stop) begin
                    w_state_d = ST_IDLE;
                end else if (start) begin
                    w_dir_d    = dir;
                    w_reload_d = reload;
                    w_state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (stop) begin
                    w_state_d = ST_IDLE;
                end else begin
                    w_tog     = w_count ^ w_init;
                    w_state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    w_state_d = ST_IDLE;
                end else if (w_pause) begin
                    w_state_d = ST_RUN;
                end else if (w_tc) begin
                    if (r_reload_q) begin
                        w_tog = w_count ^ w_init;
                    end else begin
                        w_state_d = ST_DONE;
                    end
                end else begin
                    w_tog = w_step;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q  <= ST_IDLE;
            r_dir_q    <= 1'b0;
            r_reload_q <= 1'b0;
            r_limit_q  <= '1;
        end else begin
            r_state_q  <= w_state_d;
            r_dir_q    <= w_dir_d;
            r_reload_q <= w_reload_d;
            r_limit_q  <= w_limit_d;
        end
    end

    tff_bank #(
        .WIDTH (WIDTH)
    ) u_bank (
        .clk (clk),
        .rst (rst),
        .tog (w_tog),
        .q   (w_count)
    );

    assign count = w_count;
    assign busy  = (r_state_q == ST_LOAD) || (r_state_q == ST_RUN);
    assign done  = (r_state_q == ST_DONE);
    assign tc    = w_tc;

endmodule

`default_nettype wire
